// File: rtl/vertex_outbuf_arbiter_pkg.sv
// Shared types for the vertex output-buffer arbitration path: the bank-to-Output-SRAM
// packet, arbiter states and a small modulo helper.
package vertex_outbuf_arbiter_pkg;

  localparam int unsigned FV_size     = 16;
  localparam int unsigned Max_Node_id = 1024;
  localparam int unsigned NODE_ID_W   = $clog2(Max_Node_id);

  typedef struct packed {
    logic                             req;
    logic                             Grant_valid;
    logic                             sos;
    logic                             eos;
    logic [0:1][FV_size-1:0]          data;
    logic [NODE_ID_W-1:0]             Node_id;
  } Bank_Req2Req_Output_SRAM;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    STREAM
  } arb_state_t;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vertex_outbuf_arbiter_if.sv
// Bank-side packet/grant bundle plus the Output SRAM port shared by the banks.
interface vertex_outbuf_arbiter_if
  import vertex_outbuf_arbiter_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4
) ();

  Bank_Req2Req_Output_SRAM [NUM_BANKS-1:0] bank_pkt;
  logic [NUM_BANKS-1:0]                    bank_grant;
  logic                                    sram_stall;
  Bank_Req2Req_Output_SRAM                 sram_pkt;

  modport master (output bank_pkt, output sram_stall, input bank_grant, input sram_pkt);
  modport slave  (input bank_pkt, input sram_stall, output bank_grant, output sram_pkt);

endinterface

// File: rtl/vertex_outbuf_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_vec,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any_valid
);

  int unsigned idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!any_valid && req_vec[idx[W-1:0]]) begin
        winner    = idx[W-1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vertex_outbuf_arbiter.sv
// Round-robin owner of the Output SRAM write port: latches bank requests, grants one
// bank per burst, forwards its beats with zero latency and aborts stalled bursts.
module vertex_outbuf_arbiter
  import vertex_outbuf_arbiter_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  vertex_outbuf_arbiter_if.slave bus,
  output logic [NUM_BANKS-1:0]  pending,
  output logic                  arb_busy,
  output logic                  proto_err
);

  localparam int unsigned PTR_W = $clog2(NUM_BANKS);
  localparam int unsigned WD_W  = $clog2(TIMEOUT);

  arb_state_t              state;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        owner;
  logic [WD_W-1:0]         wd_cnt;
  logic [NUM_BANKS-1:0]    grant_q;

  logic [NUM_BANKS-1:0]    req_vec;
  logic [NUM_BANKS-1:0]    gv_vec;
  logic [NUM_BANKS-1:0]    owner_mask;
  Bank_Req2Req_Output_SRAM owner_pkt;
  logic                    busy;
  logic                    owner_gv;
  logic                    err_now;
  logic [PTR_W-1:0]        winner;
  logic                    any_valid;
  logic [PTR_W-1:0]        next_ptr;

  rr_pick #(.N(NUM_BANKS), .W(PTR_W)) u_rr_pick (
    .req_vec  (pending),
    .ptr      (rr_ptr),
    .winner   (winner),
    .any_valid(any_valid)
  );

  always_comb begin
    req_vec = '0;
    gv_vec  = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      req_vec[i] = bus.bank_pkt[i].req;
      gv_vec[i]  = bus.bank_pkt[i].Grant_valid;
    end
    busy       = (state != IDLE);
    owner_pkt  = bus.bank_pkt[owner];
    owner_gv   = busy && owner_pkt.Grant_valid;
    owner_mask = busy ? (NUM_BANKS'(1'b1) << owner) : '0;
    next_ptr   = PTR_W'(wrap_inc(32'(owner), NUM_BANKS));
    // Outside a burst there is no owner, so every valid beat is a stray one.
    err_now    = (|(req_vec & pending)) || (|(req_vec & owner_mask)) ||
                 (|(gv_vec & ~owner_mask));
  end

  always_comb begin
    bus.sram_pkt = '0;
    if (busy) begin
      bus.sram_pkt     = owner_pkt;
      bus.sram_pkt.req = 1'b0;
    end
  end

  always_comb begin
    bus.bank_grant = grant_q;
    arb_busy       = busy;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pending   <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
      wd_cnt    <= '0;
      grant_q   <= '0;
      proto_err <= 1'b0;
    end else begin
      pending <= (pending & ~grant_q) | req_vec;
      grant_q <= '0;
      if (err_now) proto_err <= 1'b1;
      case (state)
        IDLE: begin
          if (any_valid && !bus.sram_stall) begin
            owner   <= winner;
            wd_cnt  <= '0;
            grant_q <= NUM_BANKS'(1'b1) << winner;
            state   <= GRANT;
          end
        end
        GRANT, STREAM: begin
          if (owner_gv && owner_pkt.eos) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end else if (owner_gv) begin
            wd_cnt <= '0;
            state  <= STREAM;
          end else if (state == STREAM && wd_cnt == WD_W'(TIMEOUT - 1)) begin
            proto_err <= 1'b1;
            state     <= IDLE;
            rr_ptr    <= next_ptr;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            state  <= STREAM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_outbuf_arbiter.sv
// Directed cycle-accurate bench for vertex_outbuf_arbiter with 4 banks, TIMEOUT=64.
module tb_vertex_outbuf_arbiter;
  import vertex_outbuf_arbiter_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned TO = 64;
  typedef Bank_Req2Req_Output_SRAM pkt_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NB-1:0] pending;
  logic          arb_busy;
  logic          proto_err;
  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  pkt_t          exp_pkt;

  vertex_outbuf_arbiter_if #(.NUM_BANKS(NB)) bus ();

  vertex_outbuf_arbiter #(.NUM_BANKS(NB), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .pending  (pending),
    .arb_busy (arb_busy),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic pkt_t mk(input logic req, input logic gv, input logic sos, input logic eos,
                              input logic [FV_size-1:0] d0, input logic [NODE_ID_W-1:0] nid);
    pkt_t p;
    p             = '0;
    p.req         = req;
    p.Grant_valid = gv;
    p.sos         = sos;
    p.eos         = eos;
    p.data[0]     = d0;
    p.data[1]     = ~d0;
    p.Node_id     = nid;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_pulse(input int unsigned b);
    bus.bank_pkt[b].req = 1'b1;
  endtask

  task automatic beat(input int unsigned b, input logic sos, input logic eos, input logic [FV_size-1:0] tag);
    bus.bank_pkt[b] = mk(1'b0, 1'b1, sos, eos, tag, NODE_ID_W'(b + 1));
  endtask

  // Non-owner banks carry junk data with Grant_valid low, which must never leak.
  task automatic junk_others(input int unsigned b);
    for (int unsigned i = 0; i < NB; i++)
      if (i != b) bus.bank_pkt[i] = mk(1'b0, 1'b0, 1'b1, 1'b1, 16'hDEAD, NODE_ID_W'(7));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.bank_pkt = '0;
    bus.sram_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    vectors++; if (bus.bank_grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant: got %b exp 0000", bus.bank_grant); end
    vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL reset_pending: got %b exp 0000", pending); end
    vectors++; if (arb_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b exp 0", arb_busy); end
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b exp 0", proto_err); end
    vectors++; if (bus.sram_pkt !== pkt_t'('0)) begin miscompares++; $display("FAIL reset_sram: got %h exp 0", bus.sram_pkt); end
  endtask

  task automatic test_single_bank();
    logic [FV_size-1:0] tags [3];
    tags = '{16'h1111, 16'h3333, 16'h5555};
    tick(); req_pulse(2);
    tick(); bus.bank_pkt = '0; #1;
    vectors++; if (pending !== 4'b0100) begin miscompares++; $display("FAIL single_pending: got %b exp 0100", pending); end
    vectors++; if (bus.bank_grant !== 4'b0000) begin miscompares++; $display("FAIL single_early_grant: got %b exp 0000", bus.bank_grant); end
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      if (k == 0) begin
        vectors++; if (bus.bank_grant !== 4'b0100) begin miscompares++; $display("FAIL single_grant: got %b exp 0100", bus.bank_grant); end
      end else begin
        vectors++; if (bus.bank_grant !== 4'b0000) begin miscompares++; $display("FAIL single_grant_pulse: got %b exp 0000", bus.bank_grant); end
      end
      beat(2, k == 0, k == 2, tags[k]);
      #1;
      exp_pkt = mk(1'b0, 1'b1, k == 0, k == 2, tags[k], NODE_ID_W'(3));
      vectors++; if (bus.sram_pkt !== exp_pkt) begin miscompares++; $display("FAIL single_beat%0d: got %h exp %h", k, bus.sram_pkt, exp_pkt); end
    end
    tick(); bus.bank_pkt = '0; #1;
    vectors++; if (arb_busy !== 1'b0) begin miscompares++; $display("FAIL single_idle: got %b exp 0", arb_busy); end
    vectors++; if (bus.sram_pkt !== pkt_t'('0)) begin miscompares++; $display("FAIL single_idle_sram: got %h exp 0", bus.sram_pkt); end
    vectors++; if (dut.rr_ptr !== 2'd3) begin miscompares++; $display("FAIL single_rr_ptr: got %0d exp 3", dut.rr_ptr); end
    vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL single_pending_clr: got %b exp 0000", pending); end
  endtask

  task automatic test_simultaneous();
    int unsigned order [3];
    logic [NB-1:0] exp_grant [3];
    logic [NB-1:0] exp_pend [3];
    order     = '{1, 3, 0};
    exp_grant = '{4'b0010, 4'b1000, 4'b0001};
    exp_pend  = '{4'b1001, 4'b0001, 4'b0000};
    // single-beat burst from bank 0 moves rr_ptr from 3 to 1
    tick(); req_pulse(0);
    tick(); bus.bank_pkt = '0;
    tick(); beat(0, 1'b1, 1'b1, 16'h0A0A); #1;
    vectors++; if (bus.bank_grant !== 4'b0001) begin miscompares++; $display("FAIL sim_pre_grant: got %b exp 0001", bus.bank_grant); end
    tick(); bus.bank_pkt = '0;
    req_pulse(0); req_pulse(1); req_pulse(3);
    tick(); bus.bank_pkt = '0; #1;
    vectors++; if (pending !== 4'b1011) begin miscompares++; $display("FAIL sim_pending0: got %b exp 1011", pending); end
    for (int unsigned k = 0; k < 3; k++) begin
      tick(); beat(order[k], 1'b1, 1'b0, 16'h2000 + 16'(k)); junk_others(order[k]); #1;
      vectors++; if (bus.bank_grant !== exp_grant[k]) begin miscompares++; $display("FAIL sim_grant%0d: got %b exp %b", k, bus.bank_grant, exp_grant[k]); end
      exp_pkt = mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h2000 + 16'(k), NODE_ID_W'(order[k] + 1));
      vectors++; if (bus.sram_pkt !== exp_pkt) begin miscompares++; $display("FAIL sim_sos%0d: got %h exp %h", k, bus.sram_pkt, exp_pkt); end
      tick(); beat(order[k], 1'b0, 1'b1, 16'h3000 + 16'(k)); #1;
      vectors++; if (pending !== exp_pend[k]) begin miscompares++; $display("FAIL sim_pending%0d: got %b exp %b", k + 1, pending, exp_pend[k]); end
      tick(); bus.bank_pkt = '0; #1;
      vectors++; if (arb_busy !== 1'b0) begin miscompares++; $display("FAIL sim_gap%0d: got %b exp 0", k, arb_busy); end
    end
    vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("FAIL sim_err: got %b exp 0", proto_err); end
  endtask

  task automatic test_stall();
    bus.sram_stall = 1'b1;
    tick(); req_pulse(0);
    for (int unsigned k = 0; k < 5; k++) begin
      tick(); bus.bank_pkt = '0; #1;
      vectors++; if (bus.bank_grant !== 4'b0000 || arb_busy !== 1'b0) begin miscompares++; $display("FAIL stall_hold%0d: got grant %b busy %b exp 0000 0", k, bus.bank_grant, arb_busy); end
      if (k == 4) bus.sram_stall = 1'b0;
    end
    vectors++; if (pending !== 4'b0001) begin miscompares++; $display("FAIL stall_pending: got %b exp 0001", pending); end
    tick(); beat(0, 1'b1, 1'b0, 16'h4000); bus.sram_stall = 1'b1; #1;
    vectors++; if (bus.bank_grant !== 4'b0001) begin miscompares++; $display("FAIL stall_grant: got %b exp 0001", bus.bank_grant); end
    tick(); beat(0, 1'b0, 1'b0, 16'h4001); #1;
    exp_pkt = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h4001, NODE_ID_W'(1));
    vectors++; if (bus.sram_pkt !== exp_pkt) begin miscompares++; $display("FAIL stall_midburst: got %h exp %h", bus.sram_pkt, exp_pkt); end
    tick(); beat(0, 1'b0, 1'b1, 16'h4002); #1;
    vectors++; if (arb_busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy: got %b exp 1", arb_busy); end
    tick(); bus.bank_pkt = '0; bus.sram_stall = 1'b0; #1;
    vectors++; if (arb_busy !== 1'b0) begin miscompares++; $display("FAIL stall_end: got %b exp 0", arb_busy); end
  endtask

  task automatic test_req_during_burst();
    tick(); req_pulse(0);
    tick(); bus.bank_pkt = '0;
    tick(); beat(0, 1'b1, 1'b0, 16'h5000);
    tick(); beat(0, 1'b0, 1'b0, 16'h5001); req_pulse(1);
    tick(); beat(0, 1'b0, 1'b1, 16'h5002); bus.bank_pkt[1] = '0; #1;
    vectors++; if (pending !== 4'b0010) begin miscompares++; $display("FAIL rdb_pending: got %b exp 0010", pending); end
    tick(); bus.bank_pkt = '0; #1;
    vectors++; if (arb_busy !== 1'b0 || bus.bank_grant !== 4'b0000) begin miscompares++; $display("FAIL rdb_idle: got busy %b grant %b exp 0 0000", arb_busy, bus.bank_grant); end
    tick(); beat(1, 1'b1, 1'b1, 16'h5100); #1;
    vectors++; if (bus.bank_grant !== 4'b0010) begin miscompares++; $display("FAIL rdb_grant: got %b exp 0010", bus.bank_grant); end
    exp_pkt = mk(1'b0, 1'b1, 1'b1, 1'b1, 16'h5100, NODE_ID_W'(2));
    vectors++; if (bus.sram_pkt !== exp_pkt) begin miscompares++; $display("FAIL rdb_beat: got %h exp %h", bus.sram_pkt, exp_pkt); end
    tick(); bus.bank_pkt = '0;
  endtask

  task automatic test_timeout();
    int unsigned busy_bad;
    busy_bad = 0;
    tick(); req_pulse(2);
    tick(); bus.bank_pkt = '0;
    tick(); beat(2, 1'b1, 1'b0, 16'h6000); req_pulse(3); #1;
    vectors++; if (bus.bank_grant !== 4'b0100) begin miscompares++; $display("FAIL to_grant: got %b exp 0100", bus.bank_grant); end
    for (int unsigned k = 1; k <= TO; k++) begin
      tick(); bus.bank_pkt = '0; #1;
      if (arb_busy !== 1'b1 || proto_err !== 1'b0) busy_bad++;
    end
    vectors++; if (busy_bad != 0) begin miscompares++; $display("FAIL to_window: got %0d early-abort cycles exp 0", busy_bad); end
    vectors++; if (pending !== 4'b1000) begin miscompares++; $display("FAIL to_pending: got %b exp 1000", pending); end
    tick(); #1;
    vectors++; if (arb_busy !== 1'b0 || proto_err !== 1'b1) begin miscompares++; $display("FAIL to_abort: got busy %b err %b exp 0 1", arb_busy, proto_err); end
    tick(); beat(3, 1'b1, 1'b1, 16'h6300); #1;
    vectors++; if (bus.bank_grant !== 4'b1000) begin miscompares++; $display("FAIL to_next_grant: got %b exp 1000", bus.bank_grant); end
    tick(); bus.bank_pkt = '0;
  endtask

  task automatic test_async_reset();
    tick(); req_pulse(0);
    tick(); bus.bank_pkt = '0;
    tick(); beat(0, 1'b1, 1'b0, 16'h7000);
    tick(); beat(0, 1'b0, 1'b0, 16'h7001); req_pulse(2);
    tick(); beat(0, 1'b0, 1'b0, 16'h7002);
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (bus.bank_grant !== 4'b0000) begin miscompares++; $display("FAIL ar_grant: got %b exp 0000", bus.bank_grant); end
    vectors++; if (bus.sram_pkt !== pkt_t'('0)) begin miscompares++; $display("FAIL ar_sram: got %h exp 0", bus.sram_pkt); end
    vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL ar_pending: got %b exp 0000", pending); end
    vectors++; if (proto_err !== 1'b0 || arb_busy !== 1'b0) begin miscompares++; $display("FAIL ar_flags: got err %b busy %b exp 0 0", proto_err, arb_busy); end
    bus.bank_pkt = '0;
    tick(); tick(); reset_n = 1'b1;
    tick(); #1;
    vectors++; if (bus.bank_grant !== 4'b0000 || arb_busy !== 1'b0) begin miscompares++; $display("FAIL ar_release: got grant %b busy %b exp 0000 0", bus.bank_grant, arb_busy); end
  endtask

  task automatic test_dup_req();
    tick(); req_pulse(1);
    tick(); req_pulse(1);
    tick(); bus.bank_pkt = '0; beat(1, 1'b1, 1'b1, 16'h8000); #1;
    vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL dup_err: got %b exp 1", proto_err); end
    vectors++; if (bus.bank_grant !== 4'b0010 || pending !== 4'b0010) begin miscompares++; $display("FAIL dup_grant: got grant %b pending %b exp 0010 0010", bus.bank_grant, pending); end
    tick(); bus.bank_pkt = '0; #1;
    vectors++; if (pending !== 4'b0000 || proto_err !== 1'b1) begin miscompares++; $display("FAIL dup_after: got pending %b err %b exp 0000 1", pending, proto_err); end
  endtask

  initial begin
    test_reset();
    test_single_bank();
    test_simultaneous();
    test_stall();
    test_req_during_burst();
    test_timeout();
    test_async_reset();
    test_dup_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 exp completion");
    $fatal(1);
  end

endmodule

// File: doc/vertex_outbuf_arbiter.md
Name: vertex_outbuf_arbiter

Overview:
- Shares the single Output SRAM write port between NUM_BANKS vertex accumulation buffer banks.
- Each bank pulses a one-cycle req when its feature vector is complete. The bank then waits for a one-cycle grant and streams two FV words per cycle, framed by sos/eos.
- This block latches pending requests and picks a winner round-robin. It issues the grant pulse, forwards the winner's packet stream to the Output SRAM, and releases the port on eos.

Parameters:
- NUM_BANKS, 4, number of requesting vertex buffer banks (2..16).
- TIMEOUT, 64, maximum idle cycles inside a granted burst before the burst is aborted.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- bank_pkt  in  NUM_BANKS x $bits(Bank_Req2Req_Output_SRAM)  per-bank packet: req, Grant_valid, sos, eos, data[0:1], Node_id.
- bank_grant  out  NUM_BANKS  one-hot, one-cycle grant pulse to a bank (drives that bank's req_grant).
- sram_stall  in  1  Output SRAM cannot accept a new burst; blocks new grants only.
- sram_pkt  out  $bits(Bank_Req2Req_Output_SRAM)  forwarded packet to the Output SRAM.
- pending  out  NUM_BANKS  latched, not-yet-granted requests.
- arb_busy  out  1  high in GRANT or STREAM.
- proto_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, pending=0, rr_ptr=0, owner=0, wd_cnt=0, bank_grant=0, proto_err=0, sram_pkt all-zero.
- Request capture: pending[i] is set on any cycle with bank_pkt[i].req=1.
- pending[i] is cleared in the cycle bank_grant[i] is driven.
- Set and clear of different bits in the same cycle are independent; both take effect.
- req from a bank whose pending bit is already set, or from the current owner before its eos, sets proto_err. The pending bit stays set.
- IDLE:
  - If |pending and !sram_stall, pick the winner: the first set bit at or after rr_ptr, wrapping modulo NUM_BANKS.
  - Register owner=winner, clear wd_cnt, go to GRANT.
  - A req arriving in the same cycle is visible for arbitration one cycle later.
- GRANT (exactly one cycle):
  - bank_grant[owner]=1; all other grant bits 0.
  - The owner responds combinationally with Grant_valid=1, sos=1 in this same cycle.
  - Go to STREAM. If that beat also carries eos=1, end the burst instead (see burst end below).
  - If Grant_valid=0 in this cycle, go to STREAM anyway and let the watchdog count.
- STREAM:
  - Beats from the owner with Grant_valid=1 are forwarded; wd_cnt is cleared on each valid beat, otherwise incremented.
  - Burst end: on Grant_valid=1 and eos=1, go to IDLE and set rr_ptr=(owner+1) mod NUM_BANKS.
  - Timeout: when wd_cnt reaches TIMEOUT-1, set proto_err, go to IDLE, and advance rr_ptr the same way (abort).
- Forwarding is combinational, zero latency:
  - In GRANT/STREAM, sram_pkt = bank_pkt[owner] with req forced to 0.
  - In IDLE, sram_pkt = 0.
  - Packets from non-owner banks with Grant_valid=1 are ignored and set proto_err.
- sram_stall is sampled only in IDLE; a burst in progress is never interrupted by it.
- Minimum spacing between consecutive bursts: one IDLE cycle.
- Back-to-back bursts from different banks need no extra gap.
- bank_grant is a registered output (state decode of GRANT plus owner register); no combinational path from bank_pkt to bank_grant.
- Widths: rr_ptr and owner are $clog2(NUM_BANKS) bits; wd_cnt is $clog2(TIMEOUT) bits.

Decomposition:
- Shared package:
  - Bank_Req2Req_Output_SRAM typedef (existing).
  - FV_size and Max_Node_id macros (existing).
  - New localparam enum arb_state_t {IDLE, GRANT, STREAM}.
- One sub-module, rr_pick:
  - Combinational round-robin priority encoder.
  - Inputs: pending vector, rr_ptr.
  - Outputs: winner index, any_valid.
  - Reusable by the weight-bank arbiter.

Test Plan:
- Single bank: bank 2 pulses req at cycle 10 and streams 3 beats (sos, -, eos) → bank_grant=4'b0100 at cycle 12 only; sram_pkt mirrors the beats on cycles 12-14; IDLE at 15; rr_ptr=3.
- Simultaneous requests: banks 0, 1, 3 pulse req in the same cycle with rr_ptr=1 → grant order 1, 3, 0; each burst is 2 beats; pending decrements 4'b1011→4'b1001→4'b0001→0.
- Stall: pending=4'b0001 with sram_stall=1 for 5 cycles → no grant; the grant issues on the first IDLE cycle after stall deasserts. A stall raised mid-burst does not cut that burst.
- Request during a burst: bank 0 is streaming and bank 1 pulses req → pending[1] is set, and bank 1 is granted on the cycle after bank 0's IDLE cycle.
- Timeout: the owner returns no eos and Grant_valid=0 after sos → after 64 cycles proto_err=1, IDLE, and the next pending bank is granted.
- Async reset mid-STREAM: reset_n low asynchronously → bank_grant=0, sram_pkt=0, pending=0 immediately; no grant in the first cycle after release.
